usr_serial_word_receiver: RTL and testbench

- Serial-to-parallel receive end for the 16-bit universal shift register's serial outputs.
- Collects DATA_WIDTH qualified serial bits, LSB-first (transmitter shifting right) or MSB-first (shifting left), and rebuilds the parallel word.
- Presents each word on a double-buffered valid/ready output port, so the next frame can be received while the previous word waits for the consumer.

---
 rtl/usr_serial_word_receiver.sv | 175 +++++++++++++++++
 tb/tb_usr_serial_word_receiver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_serial_word_receiver.sv
// Serial-to-parallel receiver: rebuilds DATA_WIDTH-bit words from a qualified bit stream and
// presents them on a double-buffered valid/ready port. Define RX_TIMEOUT_EN to abort stalled frames.
//
// state   | meaning
// IDLE    | no frame in progress; waiting for a qualified start bit
// RECEIVE | frame in progress; accepting bits until the word is complete

module usr_serial_word_receiver #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    input  logic                          Rx_Start_In,
    input  logic                          Rx_Bit_Valid_In,
    input  logic                          Rx_Serial_Data_In,
    input  logic                          Rx_Direction_In,
    input  logic                          Data_Ready_In,
    input  logic                          Error_Clear_In,
    output logic [DATA_WIDTH-1:0]         Parallel_Data_Out,
    output logic                          Data_Valid_Out,
    output logic                          Busy_Out,
    output logic [$clog2(DATA_WIDTH):0]   Bit_Count_Out,
    output logic                          Overrun_Error_Out,
    output logic                          Timeout_Error_Out
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] sr, sr_next;
    logic [DATA_WIDTH-1:0] word_out, word_out_next;
    logic [DATA_WIDTH-1:0] shift_base, shifted;
    logic                  dir, dir_next, frame_dir;
    logic [CW-1:0]         count, count_next, count_inc;
    logic                  valid, valid_next;
    logic                  overrun, overrun_next, overrun_set;
    logic                  timeout, timeout_next;
    logic                  start_bit, complete;

`ifdef RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);

    logic [IW-1:0] idle_cnt, idle_cnt_next, idle_inc;

    assign idle_inc = idle_cnt + IW'(1);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    assign start_bit  = Rx_Start_In && Rx_Bit_Valid_In;
    assign frame_dir  = start_bit ? Rx_Direction_In : dir;
    // A start bit always shifts into a cleared register so a resync never leaks partial bits.
    assign shift_base = start_bit ? '0 : sr;
    assign shifted    = frame_dir ? {shift_base[DATA_WIDTH-2:0], Rx_Serial_Data_In}
                                  : {Rx_Serial_Data_In, shift_base[DATA_WIDTH-1:1]};
    assign count_inc  = start_bit ? ONE_COUNT : count + ONE_COUNT;
    assign complete   = (state == RECEIVE) && Rx_Bit_Valid_In && (count_inc == LAST_COUNT);

    always_comb begin
        state_next    = state;
        sr_next       = sr;
        dir_next      = dir;
        count_next    = count;
        word_out_next = word_out;
        valid_next    = valid;
        overrun_next  = overrun;
        overrun_set   = 1'b0;
        timeout_next  = 1'b0;
`ifdef RX_TIMEOUT_EN
        idle_cnt_next = '0;
`endif

        case (state)
            IDLE: begin
                if (start_bit) begin
                    dir_next   = Rx_Direction_In;
                    sr_next    = shifted;
                    count_next = ONE_COUNT;
                    state_next = RECEIVE;
                end
            end
            RECEIVE: begin
                if (Rx_Bit_Valid_In) begin
                    dir_next   = frame_dir;
                    sr_next    = shifted;
                    count_next = count_inc;
                    if (complete) begin
                        count_next = '0;
                        state_next = IDLE;
                    end
                end else begin
`ifdef RX_TIMEOUT_EN
                    idle_cnt_next = idle_inc;
                    if (idle_inc == IDLE_LIMIT) begin
                        idle_cnt_next = '0;
                        sr_next       = '0;
                        count_next    = '0;
                        timeout_next  = 1'b1;
                        state_next    = IDLE;
                    end
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Output buffer: a completed word loads if the slot is empty or draining this edge.
        if (complete) begin
            if (!valid || Data_Ready_In) begin
                word_out_next = shifted;
                valid_next    = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (valid && Data_Ready_In) begin
            valid_next = 1'b0;
        end

        if (Error_Clear_In) begin
            overrun_next = 1'b0;
        end
        if (overrun_set) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state    <= IDLE;
            sr       <= '0;
            dir      <= 1'b0;
            count    <= '0;
            word_out <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
`ifdef RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            state    <= state_next;
            sr       <= sr_next;
            dir      <= dir_next;
            count    <= count_next;
            word_out <= word_out_next;
            valid    <= valid_next;
            overrun  <= overrun_next;
            timeout  <= timeout_next;
`ifdef RX_TIMEOUT_EN
            idle_cnt <= idle_cnt_next;
`endif
        end
    end

    assign Parallel_Data_Out = word_out;
    assign Data_Valid_Out    = valid;
    assign Busy_Out          = (state == RECEIVE);
    assign Bit_Count_Out     = count;
    assign Overrun_Error_Out = overrun;
    assign Timeout_Error_Out = timeout;

endmodule

// File: tb/tb_usr_serial_word_receiver.sv
// Bench for usr_serial_word_receiver: a frame-level model checked every cycle plus literal
// expectations on the directed scenarios.

module tb_usr_serial_word_receiver;

    localparam int W   = 16;
    localparam int TMO = 32;

    logic          clk;
    logic          rst, start, bv, sbit, dir, ready, clr;
    logic [W-1:0]  pdata;
    logic          dvalid, busy, ovr, tmo;
    logic [4:0]    bcount;

    int n_checks = 0;
    int n_err    = 0;

    usr_serial_word_receiver #(
        .DATA_WIDTH     (W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk_In            (clk),
        .Reset_In          (rst),
        .Rx_Start_In       (start),
        .Rx_Bit_Valid_In   (bv),
        .Rx_Serial_Data_In (sbit),
        .Rx_Direction_In   (dir),
        .Data_Ready_In     (ready),
        .Error_Clear_In    (clr),
        .Parallel_Data_Out (pdata),
        .Data_Valid_Out    (dvalid),
        .Busy_Out          (busy),
        .Bit_Count_Out     (bcount),
        .Overrun_Error_Out (ovr),
        .Timeout_Error_Out (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model: bits are collected in arrival order and weighted by direction.
    bit         m_live = 0;
    bit         m_busy, m_dir, m_valid, m_ovr, m_tmo;
    int         m_nbits, m_idle;
    int         m_bits [W];
    logic [W-1:0] m_data;

    task automatic model_step();
        int  word;
        bit  done;
        bit  ovr_set;
        if (rst) begin
            m_live  = 1;
            m_busy  = 0;
            m_dir   = 0;
            m_valid = 0;
            m_ovr   = 0;
            m_tmo   = 0;
            m_nbits = 0;
            m_idle  = 0;
            m_data  = '0;
            return;
        end
        word    = 0;
        done    = 0;
        ovr_set = 0;
        m_tmo   = 0;
        if (bv && (m_busy || start)) begin
            if (start) begin
                m_dir   = dir;
                m_nbits = 0;
            end
            m_bits[m_nbits] = int'(sbit);
            m_nbits++;
            m_busy = 1;
            m_idle = 0;
            if (m_nbits == W) begin
                for (int i = 0; i < W; i++)
                    word += m_dir ? (m_bits[i] << (W - 1 - i)) : (m_bits[i] << i);
                done    = 1;
                m_busy  = 0;
                m_nbits = 0;
            end
        end else if (m_busy) begin
`ifdef RX_TIMEOUT_EN
            m_idle++;
            if (m_idle == TMO) begin
                m_busy  = 0;
                m_nbits = 0;
                m_idle  = 0;
                m_tmo   = 1;
            end
`endif
        end
        if (done) begin
            if (!m_valid || ready) begin
                m_data  = word[W-1:0];
                m_valid = 1;
            end else begin
                ovr_set = 1;
            end
        end else if (m_valid && ready) begin
            m_valid = 0;
        end
        if (clr)     m_ovr = 0;
        if (ovr_set) m_ovr = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("valid",   32'(dvalid), 32'(m_valid));
            chk("data",    32'(pdata),  32'(m_data));
            chk("busy",    32'(busy),   32'(m_busy));
            chk("count",   32'(bcount), 32'(m_nbits));
            chk("overrun", 32'(ovr),    32'(m_ovr));
            chk("timeout", 32'(tmo),    32'(m_tmo));
        end
    end

    task automatic step(input bit s, input bit v, input bit b, input bit d,
                        input bit rdy, input bit c, input bit r);
        start = s; bv = v; sbit = b; dir = d; ready = rdy; clr = c; rst = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, rdy, 0, 0);
    endtask

    task automatic send(input logic [W-1:0] w, input bit d, input int first, input int last,
                        input int gap, input bit rdy, input bit last_rdy);
        for (int i = first; i < last; i++) begin
            bit b;
            b = d ? w[W-1-i] : w[i];
            step(i == 0, 1, b, d, (i == last - 1) ? last_rdy : rdy, 0, 0);
            if (i != last - 1)
                for (int g = 0; g < gap; g++) step(0, 0, 0, d, rdy, 0, 0);
        end
    endtask

    initial begin
        start = 0; bv = 0; sbit = 0; dir = 0; ready = 0; clr = 0; rst = 1;
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("reset_valid", 32'(dvalid), 32'd0);
        chk("reset_count", 32'(bcount), 32'd0);
        idle(2, 1);

        // LSB-first, back-to-back bits, consumer ready
        send(16'hA5C3, 0, 0, 8, 0, 1, 1);
        chk("lsb_busy_mid", 32'(busy),   32'd1);
        chk("lsb_cnt_mid",  32'(bcount), 32'd8);
        send(16'hA5C3, 0, 8, 16, 0, 1, 1);
        chk("lsb_valid", 32'(dvalid), 32'd1);
        chk("lsb_data",  32'(pdata),  32'h0000A5C3);
        chk("lsb_busy",  32'(busy),   32'd0);
        idle(1, 1);
        chk("lsb_drain", 32'(dvalid), 32'd0);

        // MSB-first, one idle cycle between bits
        send(16'h1234, 1, 0, 16, 1, 1, 1);
        chk("msb_data",  32'(pdata),  32'h00001234);
        chk("msb_count", 32'(bcount), 32'd0);
        idle(2, 1);

        // Backpressure and overrun
        send(16'h00FF, 0, 0, 16, 0, 0, 0);
        send(16'hFF00, 0, 0, 16, 0, 0, 0);
        chk("ovr_hold", 32'(pdata), 32'h000000FF);
        chk("ovr_set",  32'(ovr),   32'd1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("ovr_clr",  32'(ovr),    32'd0);
        chk("ovr_kept", 32'(dvalid), 32'd1);
        idle(2, 1);

        // Completion on the same edge as a transfer
        send(16'hBEEF, 0, 0, 16, 0, 0, 0);
        send(16'hCAFE, 1, 0, 16, 0, 0, 1);
        chk("simul_data",  32'(pdata),  32'h0000CAFE);
        chk("simul_valid", 32'(dvalid), 32'd1);
        chk("simul_ovr",   32'(ovr),    32'd0);
        idle(2, 1);

        // Resynchronisation mid-frame
        send(16'h0033, 0, 0, 7, 0, 1, 1);
        send(16'h5A5A, 0, 0, 1, 0, 1, 1);
        chk("resync_count", 32'(bcount), 32'd1);
        send(16'h5A5A, 0, 1, 16, 0, 1, 1);
        chk("resync_data", 32'(pdata), 32'h00005A5A);
        idle(2, 1);

        // Reset mid-frame
        send(16'h0F0F, 1, 0, 9, 0, 1, 1);
        chk("pre_rst_count", 32'(bcount), 32'd9);
        step(0, 0, 0, 0, 1, 0, 1);
        chk("rst_busy",  32'(busy),   32'd0);
        chk("rst_count", 32'(bcount), 32'd0);
        chk("rst_valid", 32'(dvalid), 32'd0);
        idle(2, 1);

        // Long stall inside a frame
        send(16'h1111, 0, 0, 16, 0, 0, 0);
        send(16'h001F, 0, 0, 5, 0, 0, 0);
`ifdef RX_TIMEOUT_EN
        idle(TMO - 1, 0);
        chk("tmo_early", 32'(tmo),  32'd0);
        chk("tmo_busy",  32'(busy), 32'd1);
        idle(1, 0);
        chk("tmo_pulse", 32'(tmo),    32'd1);
        chk("tmo_idle",  32'(busy),   32'd0);
        chk("tmo_valid", 32'(dvalid), 32'd1);
        chk("tmo_data",  32'(pdata),  32'h00001111);
        idle(1, 0);
        chk("tmo_once",  32'(tmo), 32'd0);
`else
        idle(TMO + 8, 0);
        chk("stall_busy",  32'(busy),   32'd1);
        chk("stall_count", 32'(bcount), 32'd5);
        chk("stall_tmo",   32'(tmo),    32'd0);
`endif
        idle(1, 1);
        send(16'h8001, 1, 0, 16, 0, 1, 1);
        chk("final_data", 32'(pdata), 32'h00008001);
        idle(3, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
